// File: rtl/ahb_apb_responder_if.sv
// AHB data-phase / APB bus bundle between the AHB master model, the responder and the APB peripherals.
// Handshake: an AHB transfer is accepted on the rising edge when Hready_in, Hready_out and an active Htrans
// (NONSEQ/SEQ) are all high; Hready_out low stretches the data phase, and APB completes on Psel & Penable.
interface ahb_apb_responder_if;
   logic        Hwrite;
   logic        Hready_in;
   logic [1:0]  Htrans;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic        Hready_out;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata;
   logic [31:0] Prdata;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;

   modport slave (
      input  Hwrite, Hready_in, Htrans, Haddr, Hwdata, Prdata,
      output Hready_out, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
   );

   modport master (
      output Hwrite, Hready_in, Htrans, Haddr, Hwdata, Prdata,
      input  Hready_out, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
   );
endinterface

// File: rtl/ahb_apb_responder.sv
// AHB responder of the AHB-to-APB bridge: decodes three contiguous APB regions and runs
// the APB SETUP/ACCESS sequence, inserting AHB wait states and a two-cycle ERROR response.
module ahb_apb_responder #(
   parameter logic [31:0] SLV_BASE    = 32'h8000_0000,
   parameter int          REGION_BITS = 26
) (
   input  logic                 Hclk,
   input  logic                 Hreset,
   ahb_apb_responder_if.slave   bus,
   output logic [2:0]           state_dbg
);

   localparam int IW = 32 - REGION_BITS;
   localparam logic [IW-1:0] BASE_IDX = SLV_BASE[31:REGION_BITS];

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WDATA  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      ERR1   = 3'd4,
      ERR2   = 3'd5
   } state_t;

   state_t      state, next_state;
   logic [31:0] addr_r;
   logic        write_r;
   logic [31:0] pwdata_r;
   logic        hready;
   logic        active;
   logic        sample;
   logic [IW-1:0] in_idx;
   logic [IW-1:0] lat_idx;
   logic        in_range;
   logic [2:0]  sel_oh;

   assign active   = (bus.Htrans == 2'b10) || (bus.Htrans == 2'b11);
   assign sample   = bus.Hready_in & hready & active;
   assign in_idx   = bus.Haddr[31:REGION_BITS] - BASE_IDX;
   assign in_range = (in_idx < IW'(3));
   assign lat_idx  = addr_r[31:REGION_BITS] - BASE_IDX;

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) state <= IDLE;
      else        state <= next_state;
   end

   // IDLE, ACCESS and ERR2 all end with Hready_out high, so each can accept the next transfer.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, ACCESS, ERR2: begin
            if (!sample)        next_state = IDLE;
            else if (!in_range) next_state = ERR1;
            else if (bus.Hwrite) next_state = WDATA;
            else                next_state = SETUP;
         end
         WDATA:   next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ERR1:    next_state = ERR2;
         default: next_state = IDLE;
      endcase
   end

   // Paddr/Pwrite come straight from the latched address phase and hold between transfers.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         addr_r   <= '0;
         write_r  <= 1'b0;
         pwdata_r <= '0;
      end else begin
         if (sample && in_range) begin
            addr_r  <= bus.Haddr;
            write_r <= bus.Hwrite;
         end
         if (state == WDATA) pwdata_r <= bus.Hwdata;
      end
   end

   always_comb begin
      sel_oh = 3'b000;
      case (lat_idx)
         IW'(0):  sel_oh = 3'b001;
         IW'(1):  sel_oh = 3'b010;
         IW'(2):  sel_oh = 3'b100;
         default: sel_oh = 3'b000;
      endcase
   end

   always_comb begin
      hready      = 1'b1;
      bus.Hresp   = 2'b00;
      bus.Pselx   = 3'b000;
      bus.Penable = 1'b0;
      bus.Hrdata  = '0;
      case (state)
         IDLE:  hready = 1'b1;
         WDATA: hready = 1'b0;
         SETUP: begin
            hready    = 1'b0;
            bus.Pselx = sel_oh;
         end
         ACCESS: begin
            hready      = 1'b1;
            bus.Pselx   = sel_oh;
            bus.Penable = 1'b1;
            if (!write_r) bus.Hrdata = bus.Prdata;
         end
         ERR1: begin
            hready    = 1'b0;
            bus.Hresp = 2'b01;
         end
         ERR2: begin
            hready    = 1'b1;
            bus.Hresp = 2'b01;
         end
         default: hready = 1'b1;
      endcase
   end

   assign bus.Hready_out = hready;
   assign bus.Paddr      = addr_r;
   assign bus.Pwrite     = write_r;
   assign bus.Pwdata     = pwdata_r;
   assign state_dbg      = state;

endmodule

// File: doc/ahb_apb_responder.md
Name: ahb_apb_responder

Overview:
AHB slave (responder) side of the AHB-to-APB bridge; it is the counterpart of the existing AHB master stimulus block. It samples AHB address-phase control and captures write data, decodes the address into one of three APB peripheral selects, and runs the APB2 SETUP/ACCESS sequence. It returns Hready_out, Hresp and Hrdata to the AHB master, inserting wait states as needed.

Parameters:
SLV_BASE, 32'h8000_0000, base address of peripheral 0; peripherals 1 and 2 follow contiguously.
REGION_BITS, 26, log2 of each peripheral region size (64 MB).

Ports:
Hclk  in  1  bus clock; all state changes on rising edge
Hreset  in  1  asynchronous reset, active-high
Hwrite  in  1  1=write, 0=read; sampled in the address phase
Hready_in  in  1  AHB HREADY from the interconnect
Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Haddr  in  32  transfer address
Hwdata  in  32  write data, valid in the data phase
Hready_out  out  1  responder ready / wait-state control
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  32  read data
Prdata  in  32  APB read data
Pselx  out  3  one-hot APB peripheral select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  32  APB address
Pwdata  out  32  APB write data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer): state goes to IDLE. Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hresp=00. Hready_out=1 while in IDLE.
- Sample condition: Hready_in=1 AND Hready_out=1 AND Htrans[1]=1. Htrans IDLE/BUSY gives a zero-wait OKAY with no APB activity.
- Decode: idx = Haddr[31:REGION_BITS] - SLV_BASE[31:REGION_BITS]. idx 0..2 is in range. Any other value is out of range.
- On a sampled in-range transfer: latch Haddr and Hwrite into internal address/write registers. The next state is WDATA for a write and SETUP for a read. An out-of-range transfer goes to ERR1 and causes no APB activity.
- States, with outputs:
  - IDLE: Hready_out=1, Hresp=00, Pselx=0, Penable=0.
  - WDATA: Hready_out=0. Latch Hwdata into Pwdata at the end of the cycle (the master holds Hwdata stable while HREADY is low). Next state is SETUP.
  - SETUP: Pselx = one-hot(idx), Penable=0, Paddr = latched address, Pwrite = latched write, Hready_out=0. Next state is ACCESS.
  - ACCESS: Pselx held, Penable=1, Hready_out=1, Hresp=00. On a read, Hrdata = Prdata (combinational pass-through). The next state follows the sample condition: WDATA, SETUP or ERR1 for a new transfer, otherwise IDLE. If the next state is IDLE, Pselx and Penable return to 0.
  - ERR1: Hready_out=0, Hresp=01. Next state is ERR2.
  - ERR2: Hready_out=1, Hresp=01. The sample condition applies, as in ACCESS.
- Hrdata=0 whenever the state is not ACCESS-read.
- Latency: a read completes 2 cycles after the address phase (data on cycle N+2). A write completes 3 cycles after the address phase (Penable on cycle N+3).
- Back-to-back transfers: a transfer sampled in ACCESS or ERR2 proceeds with no IDLE bubble. Penable drops to 0 and Pselx updates on the SETUP cycle.
- Paddr, Pwrite and Pwdata hold their values after a transfer until the next SETUP or WDATA.
- Hready_in=0 in IDLE or ACCESS: the transfer is not sampled and the state does not advance on account of it.

Test Plan:
- Single write: Haddr=32'h8000_0001, NONSEQ, Hwrite=1; Hwdata=32'h8000_5441 next cycle -> Hready_out low for 2 cycles; Pselx=001 with Penable=0, then Penable=1; Paddr=32'h8000_0001; Pwdata=32'h8000_5441; Hresp=00.
- Single read: Haddr=32'h8400_0010, Prdata=32'hDEAD_BEEF -> Pselx=010, Pwrite=0; Hrdata=32'hDEAD_BEEF in the ACCESS cycle with Hready_out=1.
- Error: Haddr=32'h9000_0000, NONSEQ -> Hresp=01 for 2 cycles, Hready_out 0 then 1; Pselx stays 000.
- Htrans=00 or 01 with various addresses -> Hready_out stays 1, no Pselx activity, Hresp=00.
- Write to 0x8800_0004 followed immediately by a read from 0x8000_0008 sampled in ACCESS -> Pselx goes 100 then 001 with no IDLE cycle; read data is correct.
- Hreset asserted during write ACCESS -> Pselx and Penable go to 0 asynchronously; Hready_out=1; the next transfer after reset release completes normally.
